// File: rtl/riscv_mem_delay_queue_if.sv
// rtl/riscv_mem_delay_queue_if.sv - val/rdy/msg request channel; master drives val/msg, slave drives rdy.
interface riscv_mem_delay_queue_if #(
  parameter int p_msg_sz = 67
);
  logic                val;
  logic                rdy;
  logic [p_msg_sz-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/riscv_mem_delay_queue.sv
// rtl/riscv_mem_delay_queue.sv - FIFO that holds each request p_latency cycles before offering it.
// Optional RISCV_MEM_DELAY_QUEUE_STATS_EN adds saturating enq/deq/full/backpressure counters.
module riscv_mem_delay_queue #(
  parameter int p_msg_sz  = 67,
  parameter int p_depth   = 4,
  parameter int p_latency = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_mem_delay_queue_if.slave        in_if,
  riscv_mem_delay_queue_if.master       out_if,
  output logic [$clog2(p_depth):0]      o_occupancy
);
  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(p_latency + 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(p_depth);
  localparam logic [TW-1:0] LP_TLOAD = TW'(p_latency - 1);

  if (p_latency < 1 || p_depth < 2 || (p_depth & (p_depth - 1)) != 0) begin : g_param_err
    $error("riscv_mem_delay_queue: need p_latency >= 1 and p_depth a power of two >= 2");
  end

  logic [p_msg_sz-1:0] r_mem   [p_depth];
  logic [TW-1:0]       r_timer [p_depth];
  logic [p_depth-1:0]  r_valid;
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [CW-1:0]       r_count;

  logic w_in_rdy;
  logic w_out_val;
  logic w_enq;
  logic w_deq;

  // Full/empty comes from the count so head==tail is never ambiguous.
  assign w_in_rdy  = (r_count < LP_DEPTH);
  assign w_out_val = r_valid[r_head] && (r_timer[r_head] == '0);
  assign w_enq     = in_if.val && w_in_rdy;
  assign w_deq     = w_out_val && out_if.rdy;

  assign in_if.rdy   = w_in_rdy;
  assign out_if.val  = w_out_val;
  assign out_if.msg  = w_out_val ? r_mem[r_head] : '0;
  assign o_occupancy = r_count;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= in_if.msg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < p_depth; i++) begin
        r_timer[i] <= '0;
      end
    end else begin
      // Every entry ages on its own, regardless of head position or out_rdy.
      for (int i = 0; i < p_depth; i++) begin
        if (r_valid[i] && r_timer[i] != '0) begin
          r_timer[i] <= r_timer[i] - 1'b1;
        end
      end
      if (w_enq) begin
        r_timer[r_tail] <= LP_TLOAD;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef RISCV_MEM_DELAY_QUEUE_STATS_EN
  logic [31:0] num_enq;
  logic [31:0] num_deq;
  logic [31:0] num_full_cycles;
  logic [31:0] num_bp_cycles;

  always_ff @(posedge clk) begin
    if (!reset) begin
      num_enq         <= '0;
      num_deq         <= '0;
      num_full_cycles <= '0;
      num_bp_cycles   <= '0;
    end else begin
      if (w_enq && num_enq != '1) begin
        num_enq <= num_enq + 1'b1;
      end
      if (w_deq && num_deq != '1) begin
        num_deq <= num_deq + 1'b1;
      end
      if (in_if.val && !w_in_rdy && num_full_cycles != '1) begin
        num_full_cycles <= num_full_cycles + 1'b1;
      end
      if (w_out_val && !out_if.rdy && num_bp_cycles != '1) begin
        num_bp_cycles <= num_bp_cycles + 1'b1;
      end
    end
  end
`else
`endif
endmodule

// File: tb/tb_riscv_mem_delay_queue.sv
// tb/tb_riscv_mem_delay_queue.sv - directed checks of latency, ordering, full, backpressure, reset, wrap.
module tb_riscv_mem_delay_queue;
  localparam int MSZ = 67;

  logic       clk;
  logic       reset;
  logic [2:0] occ;
  int         checks;
  int         failures;

  riscv_mem_delay_queue_if #(.p_msg_sz(MSZ)) in_if ();
  riscv_mem_delay_queue_if #(.p_msg_sz(MSZ)) out_if ();

  riscv_mem_delay_queue #(
    .p_msg_sz  (MSZ),
    .p_depth   (4),
    .p_latency (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (in_if),
    .out_if      (out_if),
    .o_occupancy (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MSZ-1:0] got, input logic [MSZ-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MSZ-1:0] mk(input logic [31:0] addr);
    return {1'b1, addr, 2'd2, addr ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [31:0] addr_of(input logic [MSZ-1:0] m);
    return m[65:34];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [MSZ-1:0] exp_q[$];
  int sent;
  int rcvd;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    in_if.val = 1'b0;
    in_if.msg = '0;
    out_if.rdy = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("rst_in_rdy", in_if.rdy, 1);
    check("rst_out_val", out_if.val, 0);
    check("rst_occ", occ, 0);
    check("rst_out_msg", out_if.msg, 0);

    // Single request, latency 2
    in_if.val = 1'b1;
    in_if.msg = mk(32'h100);
    step();
    in_if.val = 1'b0;
    check("single_occ_e1", occ, 1);
    check("single_val_e1", out_if.val, 0);
    step();
    check("single_val_e2", out_if.val, 1);
    check("single_addr", addr_of(out_if.msg), 32'h100);
    step();
    check("single_hold_val", out_if.val, 1);
    check("single_hold_occ", occ, 1);
    out_if.rdy = 1'b1;
    step();
    check("single_deq_val", out_if.val, 0);
    check("single_deq_occ", occ, 0);

    // Back-to-back, 8 requests, out_rdy held high
    for (int k = 0; k < 11; k++) begin
      in_if.val = (k < 8);
      in_if.msg = mk(32'h300 + k);
      step();
      check("b2b_val", out_if.val, (k >= 1 && k <= 8));
      if (k >= 1 && k <= 8) begin
        check("b2b_addr", addr_of(out_if.msg), 32'h300 + k - 1);
      end
    end
    in_if.val = 1'b0;
    check("b2b_occ_end", occ, 0);

    // Fill to full with out_rdy low
    out_if.rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_if.val = 1'b1;
      in_if.msg = mk(32'h400 + k);
      step();
    end
    check("full_occ", occ, 4);
    check("full_in_rdy", in_if.rdy, 0);
    in_if.msg = mk(32'h404);
    step();
    check("full_5th_occ", occ, 4);
    check("full_5th_in_rdy", in_if.rdy, 0);
    check("full_head", addr_of(out_if.msg), 32'h400);
    in_if.val = 1'b0;
    out_if.rdy = 1'b1;
    step();
    out_if.rdy = 1'b0;
    check("full_pop_occ", occ, 3);
    check("full_pop_in_rdy", in_if.rdy, 1);
    check("full_pop_head", addr_of(out_if.msg), 32'h401);
    out_if.rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      check("full_drain_addr", addr_of(out_if.msg), 32'h400 + k);
      step();
    end
    check("full_drain_occ", occ, 0);
    out_if.rdy = 1'b0;

    // Backpressure hold on a mature head
    in_if.val = 1'b1;
    in_if.msg = mk(32'h200);
    step();
    in_if.msg = mk(32'h201);
    step();
    in_if.val = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_val", out_if.val, 1);
      check("bp_msg", out_if.msg, mk(32'h200));
      step();
    end
    out_if.rdy = 1'b1;
    step();
    out_if.rdy = 1'b0;
    check("bp_next_val", out_if.val, 1);
    check("bp_next_addr", addr_of(out_if.msg), 32'h201);
    out_if.rdy = 1'b1;
    step();
    out_if.rdy = 1'b0;
    check("bp_empty_occ", occ, 0);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) begin
      in_if.val = 1'b1;
      in_if.msg = mk(32'h500 + k);
      step();
    end
    in_if.val = 1'b0;
    check("mid_pre_occ", occ, 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_out_val", out_if.val, 0);
    check("mid_occ", occ, 0);
    check("mid_in_rdy", in_if.rdy, 1);
    in_if.val = 1'b1;
    in_if.msg = mk(32'h600);
    step();
    in_if.val = 1'b0;
    check("mid_new_val_e1", out_if.val, 0);
    step();
    check("mid_new_val_e2", out_if.val, 1);
    check("mid_new_addr", addr_of(out_if.msg), 32'h600);
    out_if.rdy = 1'b1;
    step();
    out_if.rdy = 1'b0;
    check("mid_drain_occ", occ, 0);
    check("mid_drain_val", out_if.val, 0);

    // Pointer wrap with random backpressure
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 12; cyc++) begin
      in_if.val = (sent < 12) && ($urandom_range(0, 3) != 0);
      in_if.msg = mk(32'h700 + sent);
      out_if.rdy = $urandom_range(0, 1);
      #1;
      if (out_if.val && out_if.rdy) begin
        check("wrap_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("wrap_data", out_if.msg, exp_q.pop_front());
        end
        rcvd++;
      end
      if (in_if.val && in_if.rdy) begin
        exp_q.push_back(in_if.msg);
        sent++;
      end
      step();
    end
    in_if.val = 1'b0;
    out_if.rdy = 1'b0;
    check("wrap_rcvd", rcvd, 12);
    check("wrap_occ_end", occ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
